// File: rtl/watch_ctrl.sv
// Stopwatch run/stop/lap/clear controller with per-button synchronise + debounce.
// Latency: button edge to state change is DB_CYCLES+4 clocks; tick every DIV clocks while running.
// Backpressure: none, because buttons and counter-chain controls are plain levels and pulses.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   clr        asynchronous active-high reset
//   btn_start  raw start/stop button (asynchronous, active-high)
//   btn_lap    raw lap button (asynchronous, active-high)
//   btn_rst    raw clear button (asynchronous, active-high)
//   tick       1-cycle count enable to the least-significant digit counter
//   pause      1 = counter chain holds its count
//   cnt_clr    1-cycle clear pulse to the counter chain
//   lap_hold   1 = display latches frozen (lap view)
//   state      FSM state: 00 idle, 01 run, 10 stop, 11 lap
module watch_ctrl #(
  parameter int DIV       = 100000,
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_rst,
  output logic       tick,
  output logic       pause,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  // Prescaler width is clog2(DIV); DIV is at least 2 so this is never zero.
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Debounce counter only needs to reach DB_CYCLES-1 before the level flips.
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Button bit order everywhere below: [0] start, [1] lap, [2] rst.
  localparam int B_START = 0;
  localparam int B_LAP   = 1;
  localparam int B_RST   = 2;

  logic [2:0]         btn_raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         deb;
  logic [2:0]         deb_prev;
  logic [2:0]         press;
  logic [2:0][CW-1:0] db_cnt;

  state_t             st;
  state_t             nxt;
  logic [PW-1:0]      presc;
  logic               run_now;
  logic               run_nxt;
  logic               ev_start;
  logic               ev_lap;
  logic               ev_rst;

  assign btn_raw = {btn_rst, btn_lap, btn_start};

  // ---------------------------------------------------------------------------
  // Button conditioning. Each button has its own two-flop synchroniser and
  // debounce counter. The debounced level only flips after DB_CYCLES
  // consecutive samples disagreeing with it; any agreeing sample restarts the
  // count, so short glitches are swallowed. A press is the registered rising
  // edge of the debounced level, so it is exactly one cycle wide and releases
  // produce nothing. clr wipes all of this, so a press that straddles clr has
  // to be debounced again from scratch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Clear beats start, start beats lap; a losing event in the same cycle is
  // simply dropped rather than queued.
  assign ev_rst   = press[B_RST];
  assign ev_start = press[B_START] & ~press[B_RST];
  assign ev_lap   = press[B_LAP] & ~press[B_START] & ~press[B_RST];

  always_comb begin
    nxt = st;
    if (ev_rst) begin
      nxt = IDLE;
    end else if (ev_start) begin
      case (st)
        IDLE:    nxt = RUN;
        RUN:     nxt = STOP;
        LAP:     nxt = STOP;
        STOP:    nxt = RUN;
        default: nxt = IDLE;
      endcase
    end else if (ev_lap) begin
      case (st)
        RUN:     nxt = LAP;
        LAP:     nxt = RUN;
        default: nxt = st;
      endcase
    end
  end

  assign run_now = (st == RUN) || (st == LAP);
  assign run_nxt = (nxt == RUN) || (nxt == LAP);

  // ---------------------------------------------------------------------------
  // FSM and registered outputs, all decoded from the next state so they change
  // on the same edge as the state itself.
  //
  // The prescaler advances only on edges where the watch is running both
  // before and after the edge. The edge that enters run/lap therefore leaves
  // it untouched, which gives a first tick exactly DIV cycles after leaving
  // idle and a remaining (DIV - held value) cycles after resuming from stop.
  // Likewise the edge that stops the watch does not advance it, so the phase
  // seen at the stop edge is the phase that resumes. Entering idle zeroes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st       <= IDLE;
      tick     <= 1'b0;
      pause    <= 1'b1;
      cnt_clr  <= 1'b0;
      lap_hold <= 1'b0;
      presc    <= '0;
    end else begin
      st       <= nxt;
      pause    <= ~run_nxt;
      lap_hold <= (nxt == LAP);
      // Pulses on every clear event, including idle -> idle.
      cnt_clr  <= ev_rst;
      tick     <= 1'b0;
      if (nxt == IDLE) begin
        presc <= '0;
      end else if (run_now && run_nxt) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl (DIV=4, DB_CYCLES=3).
// Each expected state/output change is queued when its button press is driven,
// then popped and compared when the DUT outputs change.
module tb_watch_ctrl;

  localparam int DIV_T = 4;
  localparam int DB_T  = 3;
  // Press driven at a negedge with cycle count c changes state at edge c+LAT.
  localparam int LAT   = DB_T + 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;
  localparam logic [1:0] S_LAP  = 2'b11;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_LAP   = 3'b010;
  localparam logic [2:0] B_RST   = 3'b100;

  logic       clk       = 1'b0;
  logic       clr       = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap   = 1'b0;
  logic       btn_rst   = 1'b0;
  logic       tick;
  logic       pause;
  logic       cnt_clr;
  logic       lap_hold;
  logic [1:0] state;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;   // cycle at which the change is seen
    int st;
    int ps;
    int lh;
    int cc;
    int tn;    // ticks in the segment that just ended
    int tf;    // first tick cycle of that segment
    int tl;    // last tick cycle of that segment
  } rec_t;

  rec_t evq[$];

  // Reference model bookkeeping (stimulus side).
  logic [1:0] m_state   = 2'b00;
  int         seg_start = 0;
  int         phase     = 0;

  // Monitor bookkeeping.
  int         seg_n     = 0;
  int         seg_first = 0;
  int         seg_last  = 0;
  logic [3:0] prev_vec  = 4'b0010;

  watch_ctrl #(
    .DIV       (DIV_T),
    .DB_CYCLES (DB_T)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_rst   (btn_rst),
    .tick      (tick),
    .pause     (pause),
    .cnt_clr   (cnt_clr),
    .lap_hold  (lap_hold),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the expected change at cycle x into state ns. Ticks of the segment
  // being closed follow from its entry cycle and entry prescaler phase: the
  // first lands DIV-phase cycles after entry, then every DIV, up to the last
  // counting edge (x itself if running continues across x, else x-1).
  task automatic sched(input int x, input logic [1:0] ns, input bit cc);
    rec_t r;
    bit   was_run;
    bit   now_run;
    int   last_e;
    was_run = (m_state == S_RUN) || (m_state == S_LAP);
    now_run = (ns == S_RUN) || (ns == S_LAP);
    last_e  = (was_run && now_run) ? x : x - 1;
    r.tn = 0;
    r.tf = 0;
    r.tl = 0;
    if (was_run) begin
      for (int t = seg_start + (DIV_T - phase); t <= last_e; t += DIV_T) begin
        if (r.tn == 0) r.tf = t;
        r.tl = t;
        r.tn++;
      end
      phase = (phase + last_e - seg_start) % DIV_T;
    end
    if (ns == S_IDLE) phase = 0;
    r.cyc = x;
    r.st  = int'(ns);
    r.ps  = now_run ? 0 : 1;
    r.lh  = (ns == S_LAP) ? 1 : 0;
    r.cc  = cc ? 1 : 0;
    evq.push_back(r);
    m_state   = ns;
    seg_start = x;
  endtask

  // Hold the given buttons for 'hold' cycles from the current negedge, then
  // release and leave time for the release to settle.
  task automatic press(input logic [2:0] m, input int hold, input bit ev,
                       input logic [1:0] ns, input bit cc);
    btn_start = m[0];
    btn_lap   = m[1];
    btn_rst   = m[2];
    if (ev) sched(cyc + LAT, ns, cc);
    repeat (hold) @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_rst   = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Monitor: sample just after each rising edge, count ticks, and pop one
  // expected record for every change of state/pause/lap_hold or clear pulse.
  always @(posedge clk) begin : mon
    rec_t       r;
    logic [3:0] vec;
    #2;
    if (tick === 1'b1) begin
      if (seg_n == 0) seg_first = cyc;
      seg_last = cyc;
      seg_n++;
    end
    vec = {state, pause, lap_hold};
    if ((vec !== prev_vec) || (cnt_clr === 1'b1)) begin
      chk("sb_avail", evq.size() > 0, 1);
      if (evq.size() > 0) begin
        r = evq.pop_front();
        chk("chg_cycle", cyc, r.cyc);
        chk("chg_state", state, r.st);
        chk("chg_pause", pause, r.ps);
        chk("chg_lap_hold", lap_hold, r.lh);
        chk("chg_cnt_clr", cnt_clr, r.cc);
        chk("seg_ticks", seg_n, r.tn);
        if (r.tn > 0) begin
          chk("seg_first_tick", seg_first, r.tf);
          chk("seg_last_tick", seg_last, r.tl);
        end
      end
      seg_n    = 0;
      prev_vec = vec;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset values while clr is held.
    repeat (3) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_pause", pause, 1);
    chk("rst_tick", tick, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_lap_hold", lap_hold, 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Debounce: a 2-cycle glitch and a lap press in idle do nothing;
    // clear in idle pulses cnt_clr; a real start press runs.
    press(B_START, 2, 1'b0, S_IDLE, 1'b0);
    press(B_LAP, 10, 1'b0, S_IDLE, 1'b0);
    press(B_RST, 10, 1'b1, S_IDLE, 1'b1);
    press(B_START, 10, 1'b1, S_RUN, 1'b0);
    repeat (7) @(negedge clk);

    // Pause with the prescaler at 2, stay stopped well over 20 cycles
    // (including an ignored lap press), then resume.
    while (((cyc + LAT - 1 - seg_start + phase) % DIV_T) != 2) @(negedge clk);
    press(B_START, 10, 1'b1, S_STOP, 1'b0);
    repeat (10) @(negedge clk);
    press(B_LAP, 10, 1'b0, S_STOP, 1'b0);
    press(B_START, 10, 1'b1, S_RUN, 1'b0);

    // Lap view in and out, then start from lap stops the watch.
    press(B_LAP, 10, 1'b1, S_LAP, 1'b0);
    repeat (5) @(negedge clk);
    press(B_LAP, 10, 1'b1, S_RUN, 1'b0);
    press(B_LAP, 10, 1'b1, S_LAP, 1'b0);
    press(B_START, 10, 1'b1, S_STOP, 1'b0);
    press(B_START, 10, 1'b1, S_RUN, 1'b0);

    // Priority: clear beats start, start beats lap.
    press(B_START | B_RST, 10, 1'b1, S_IDLE, 1'b1);
    press(B_START, 10, 1'b1, S_RUN, 1'b0);
    press(B_START | B_LAP, 10, 1'b1, S_STOP, 1'b0);
    press(B_RST, 10, 1'b1, S_IDLE, 1'b1);
    press(B_START, 10, 1'b1, S_RUN, 1'b0);
    press(B_LAP, 10, 1'b1, S_LAP, 1'b0);
    press(B_RST | B_LAP, 10, 1'b1, S_IDLE, 1'b1);

    // Asynchronous clr while in lap view: outputs return to reset values
    // in the same cycle.
    press(B_START, 10, 1'b1, S_RUN, 1'b0);
    press(B_LAP, 10, 1'b1, S_LAP, 1'b0);
    repeat (3) @(negedge clk);
    sched(cyc + 1, S_IDLE, 1'b0);
    clr = 1'b1;
    #1;
    chk("async_state", state, S_IDLE);
    chk("async_pause", pause, 1);
    chk("async_tick", tick, 0);
    chk("async_cnt_clr", cnt_clr, 0);
    chk("async_lap_hold", lap_hold, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Start held across a 1-cycle clr in mid-debounce: the press is only
    // accepted after a full fresh debounce from clr release.
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sched(cyc + LAT, S_RUN, 1'b0);
    repeat (12) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);

    // Stop to close the final running segment, then drain.
    press(B_START, 10, 1'b1, S_STOP, 1'b0);
    repeat (10) @(negedge clk);
    chk("sb_drain", evq.size(), 0);
    chk("tail_ticks", seg_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
